// File: rtl/csr_if.sv
`default_nettype none
// ============================================================
// csr_if : CSR access bus between the decode stage and csr_unit
// Rev 1.0
// ============================================================
interface csr_if #(
    parameter int XLEN = 32
);
    logic [1:0]      csr_op;
    logic            csr_read;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_info;
    logic [XLEN-1:0] csr_read_data;
    logic            csr_illegal;

    modport master (
        output csr_op, csr_read, csr_addr, csr_info,
        input  csr_read_data, csr_illegal
    );

    modport slave (
        input  csr_op, csr_read, csr_addr, csr_info,
        output csr_read_data, csr_illegal
    );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================
// csr_unit : machine-mode CSR file with trap entry/return and counters
// Rev 1.0
// ============================================================
module csr_unit #(
    parameter int XLEN        = 32,
    parameter int HART_ID     = 0,
    parameter int CNT_WIDTH   = 64,
    parameter bit VECTORED_EN = 1'b1
) (
    input  wire              clk,
    input  wire              rst,
    csr_if.slave             bus,
    input  wire              ent_trap,
    input  wire              ext_trap,
    input  wire [XLEN-1:0]   trap_cause,
    input  wire [XLEN-1:0]   trap_pc,
    input  wire [XLEN-1:0]   trap_val,
    input  wire              instr_retire,
    input  wire              irq_msip,
    input  wire              irq_mtip,
    input  wire              irq_meip,
    output logic             irq_pending,
    output logic [XLEN-1:0]  trap_target,
    output logic [XLEN-1:0]  mepc_out
);
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_SET   = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTIN = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    logic                 mstatus_mie;
    logic                 mstatus_mpie;
    logic [2:0]           mie_bits;      // {meie, mtie, msie}
    logic [2:0]           mip_bits;      // {meip, mtip, msip}
    logic [XLEN-3:0]      mtvec_base;
    logic                 mtvec_mode;
    logic                 inhibit_cy;
    logic                 inhibit_ir;
    logic [XLEN-1:0]      mscratch;
    logic [XLEN-1:0]      mepc;
    logic [XLEN-1:0]      mcause;
    logic [XLEN-1:0]      mtval;
    logic [CNT_WIDTH-1:0] mcycle;
    logic [CNT_WIDTH-1:0] minstret;

    logic [63:0]          cyc64;
    logic [63:0]          ins64;
    logic [XLEN-1:0]      cur;
    logic                 implemented;
    logic                 illegal;
    logic                 sw_we;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      base_addr;

    assign cyc64 = 64'(mcycle);
    assign ins64 = 64'(minstret);

    always_comb begin
        cur         = '0;
        implemented = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                cur[12:11] = 2'b11;
                cur[7]     = mstatus_mpie;
                cur[3]     = mstatus_mie;
            end
            ADDR_MIE: begin
                cur[11] = mie_bits[2];
                cur[7]  = mie_bits[1];
                cur[3]  = mie_bits[0];
            end
            ADDR_MIP: begin
                cur[11] = mip_bits[2];
                cur[7]  = mip_bits[1];
                cur[3]  = mip_bits[0];
            end
            ADDR_MTVEC:    cur = {mtvec_base, 1'b0, mtvec_mode};
            ADDR_MCOUNTIN: begin
                cur[2] = inhibit_ir;
                cur[0] = inhibit_cy;
            end
            ADDR_MSCRATCH: cur = mscratch;
            ADDR_MEPC:     cur = mepc;
            ADDR_MCAUSE:   cur = mcause;
            ADDR_MTVAL:    cur = mtval;
            ADDR_MCYCLE:   cur = cyc64[31:0];
            ADDR_MCYCLEH:  cur = cyc64[63:32];
            ADDR_MINSTRET: cur = ins64[31:0];
            ADDR_MINSTRH:  cur = ins64[63:32];
            ADDR_MHARTID:  cur = XLEN'(HART_ID);
            default:       implemented = 1'b0;
        endcase
    end

    always_comb begin
        wdata = bus.csr_info;
        case (bus.csr_op)
            OP_SET:   wdata = cur | bus.csr_info;
            OP_CLEAR: wdata = cur & ~bus.csr_info;
            default:  wdata = bus.csr_info;
        endcase
    end

    assign illegal = (((bus.csr_read || bus.csr_op != 2'b00) && !implemented) ||
                      (bus.csr_op != 2'b00 && bus.csr_addr[11:10] == 2'b11));

    // Set/clear with a zero operand is a pure read: no counter load, no increment stall.
    assign sw_we = (bus.csr_op != 2'b00) && !illegal &&
                   !(bus.csr_op != OP_WRITE && bus.csr_info == '0);

    assign bus.csr_read_data = (!rst && bus.csr_read && !illegal) ? cur : '0;
    assign bus.csr_illegal   = !rst && illegal;

    assign base_addr   = {mtvec_base, 2'b00};
    assign trap_target = rst ? '0 :
                         (mtvec_mode && trap_cause[XLEN-1]) ?
                         base_addr + {trap_cause[XLEN-3:0], 2'b00} : base_addr;
    assign irq_pending = !rst && mstatus_mie && |(mip_bits & mie_bits);
    assign mepc_out    = rst ? '0 : mepc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_bits     <= '0;
            mip_bits     <= '0;
            mtvec_base   <= '0;
            mtvec_mode   <= 1'b0;
            inhibit_cy   <= 1'b0;
            inhibit_ir   <= 1'b0;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            mip_bits <= {irq_meip, irq_mtip, irq_msip};

            if (ent_trap) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (ext_trap) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (sw_we && bus.csr_addr == ADDR_MSTATUS) begin
                mstatus_mie  <= wdata[3];
                mstatus_mpie <= wdata[7];
            end

            if (sw_we && bus.csr_addr == ADDR_MIE)
                mie_bits <= {wdata[11], wdata[7], wdata[3]};
            if (sw_we && bus.csr_addr == ADDR_MTVEC) begin
                mtvec_base <= wdata[XLEN-1:2];
                mtvec_mode <= VECTORED_EN ? wdata[0] : 1'b0;
            end
            if (sw_we && bus.csr_addr == ADDR_MCOUNTIN) begin
                inhibit_cy <= wdata[0];
                inhibit_ir <= wdata[2];
            end
            if (sw_we && bus.csr_addr == ADDR_MSCRATCH)
                mscratch <= wdata;

            if (ent_trap) begin
                mepc   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause <= trap_cause;
                mtval  <= trap_val;
            end else if (sw_we) begin
                if (bus.csr_addr == ADDR_MEPC)   mepc   <= {wdata[XLEN-1:2], 2'b00};
                if (bus.csr_addr == ADDR_MCAUSE) mcause <= wdata;
                if (bus.csr_addr == ADDR_MTVAL)  mtval  <= wdata;
            end

            if (sw_we && bus.csr_addr == ADDR_MCYCLE)
                mcycle <= CNT_WIDTH'({cyc64[63:32], wdata});
            else if (sw_we && bus.csr_addr == ADDR_MCYCLEH)
                mcycle <= CNT_WIDTH'({wdata, cyc64[31:0]});
            else if (!inhibit_cy)
                mcycle <= mcycle + 1'b1;

            if (sw_we && bus.csr_addr == ADDR_MINSTRET)
                minstret <= CNT_WIDTH'({ins64[63:32], wdata});
            else if (sw_we && bus.csr_addr == ADDR_MINSTRH)
                minstret <= CNT_WIDTH'({wdata, ins64[31:0]});
            else if (instr_retire && !inhibit_ir)
                minstret <= minstret + 1'b1;
        end
    end

    wire unused_bits = &{1'b0, trap_pc[1:0], trap_cause[XLEN-2]};
endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================
// tb_csr_unit : directed self-checking bench for csr_unit
// Rev 1.0
// ============================================================
module tb_csr_unit;
    localparam int HART = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        ent_trap, ext_trap, instr_retire;
    logic        irq_msip, irq_mtip, irq_meip;
    logic [31:0] trap_cause, trap_pc, trap_val;
    logic        irq_pending;
    logic [31:0] trap_target, mepc_out;
    int          n_checks = 0;
    int          n_err    = 0;

    csr_if #(.XLEN(32)) bus ();

    csr_unit #(.XLEN(32), .HART_ID(HART), .CNT_WIDTH(64), .VECTORED_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ent_trap     (ent_trap),
        .ext_trap     (ext_trap),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_val     (trap_val),
        .instr_retire (instr_retire),
        .irq_msip     (irq_msip),
        .irq_mtip     (irq_mtip),
        .irq_meip     (irq_meip),
        .irq_pending  (irq_pending),
        .trap_target  (trap_target),
        .mepc_out     (mepc_out)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
        bus.csr_op   = op;
        bus.csr_addr = addr;
        bus.csr_info = data;
        step();
        bus.csr_op   = 2'b00;
        bus.csr_info = '0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_read = 1'b1;
        bus.csr_addr = addr;
        #1;
        chk(tag, bus.csr_read_data, exp);
        bus.csr_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ent_trap = 0; ext_trap = 0; instr_retire = 0;
        irq_msip = 0; irq_mtip = 0; irq_meip = 0;
        trap_cause = '0; trap_pc = '0; trap_val = '0;
        bus.csr_op = 2'b00; bus.csr_read = 1'b0; bus.csr_addr = '0; bus.csr_info = '0;

        // Outputs held at zero while in reset
        step();
        rd("rst_rdata", 12'h300, 32'h0);
        bus.csr_read = 1'b1; bus.csr_addr = 12'h7C0; #1;
        chk("rst_illegal", {31'b0, bus.csr_illegal}, 32'h0);
        bus.csr_read = 1'b0;
        chk("rst_irq", {31'b0, irq_pending}, 32'h0);
        chk("rst_target", trap_target, 32'h0);
        chk("rst_mepc_out", mepc_out, 32'h0);
        step();
        rst = 1'b0;

        // Ten idle cycles after reset
        repeat (10) step();
        rd("mcycle_10", 12'hB00, 32'd10);
        rd("minstret_0", 12'hB02, 32'd0);
        rd("mhartid", 12'hF14, HART);
        rd("mstatus_rst", 12'h300, 32'h1800);

        // Counter carry into the high half
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB80, 32'h0);
        rd("mcycle_pre", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_pre", 12'hB80, 32'h0);
        step();
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);

        instr_retire = 1'b1;
        repeat (3) step();
        instr_retire = 1'b0;
        rd("minstret_3", 12'hB02, 32'd3);

        // Interrupt pending and vectored trap entry
        wr(2'b10, 12'h300, 32'h8);
        rd("mstatus_set", 12'h300, 32'h1808);
        wr(2'b01, 12'h305, 32'h1003);
        rd("mtvec_bit1", 12'h305, 32'h1001);
        wr(2'b01, 12'h304, 32'h80);
        rd("mie", 12'h304, 32'h80);
        irq_mtip = 1'b1;
        #1;
        chk("irq_latency", {31'b0, irq_pending}, 32'h0);
        step();
        chk("irq_pending", {31'b0, irq_pending}, 32'h1);
        rd("mip", 12'h344, 32'h80);
        trap_cause = 32'h0000_0007;
        #1;
        chk("target_sync", trap_target, 32'h1000);
        trap_cause = 32'h8000_0007; trap_pc = 32'h1236; trap_val = 32'hDEAD;
        #1;
        chk("target_vec", trap_target, 32'h101C);
        ent_trap = 1'b1;
        step();
        ent_trap = 1'b0;
        rd("mepc_trap", 12'h341, 32'h1234);
        chk("mepc_out", mepc_out, 32'h1234);
        rd("mstatus_trap", 12'h300, 32'h1880);
        rd("mcause", 12'h342, 32'h8000_0007);
        rd("mtval", 12'h343, 32'hDEAD);
        chk("irq_masked", {31'b0, irq_pending}, 32'h0);

        // Trap return
        ext_trap = 1'b1;
        step();
        ext_trap = 1'b0;
        rd("mstatus_mret", 12'h300, 32'h1888);
        chk("irq_reenabled", {31'b0, irq_pending}, 32'h1);

        // Illegal accesses and ignored writes
        bus.csr_op = 2'b01; bus.csr_addr = 12'hF14; bus.csr_info = 32'h123; #1;
        chk("illegal_ro", {31'b0, bus.csr_illegal}, 32'h1);
        step();
        bus.csr_op = 2'b00;
        rd("mhartid_kept", 12'hF14, HART);
        bus.csr_read = 1'b1; bus.csr_addr = 12'h7C0; #1;
        chk("illegal_unimp", {31'b0, bus.csr_illegal}, 32'h1);
        chk("illegal_data", bus.csr_read_data, 32'h0);
        bus.csr_read = 1'b0;
        bus.csr_op = 2'b01; bus.csr_addr = 12'h344; bus.csr_info = 32'h0; #1;
        chk("mip_wr_legal", {31'b0, bus.csr_illegal}, 32'h0);
        step();
        bus.csr_op = 2'b00;
        rd("mip_ignored", 12'h344, 32'h80);
        wr(2'b11, 12'h300, 32'h0);
        rd("clear_zero", 12'h300, 32'h1888);
        wr(2'b01, 12'h340, 32'hA5A5_5A5A);
        rd("mscratch", 12'h340, 32'hA5A5_5A5A);

        // Trap beats a same-cycle software write to mepc
        ent_trap = 1'b1; trap_pc = 32'h2000; trap_cause = 32'hB;
        wr(2'b01, 12'h341, 32'h40);
        ent_trap = 1'b0;
        rd("mepc_prio", 12'h341, 32'h2000);
        rd("mcause_prio", 12'h342, 32'hB);
        rd("mstatus_prio", 12'h300, 32'h1880);
        wr(2'b01, 12'h341, 32'h43);
        rd("mepc_align", 12'h341, 32'h40);

        // Counter inhibit freeze and resume
        wr(2'b01, 12'hB00, 32'h100);
        wr(2'b01, 12'hB02, 32'h20);
        wr(2'b10, 12'h320, 32'h5);
        rd("inhibit_set", 12'h320, 32'h5);
        instr_retire = 1'b1;
        repeat (3) step();
        instr_retire = 1'b0;
        rd("mcycle_frozen", 12'hB00, 32'h102);
        rd("minstret_frozen", 12'hB02, 32'h20);
        wr(2'b11, 12'h320, 32'h5);
        rd("inhibit_clr", 12'h320, 32'h0);
        instr_retire = 1'b1;
        repeat (2) step();
        instr_retire = 1'b0;
        rd("mcycle_resume", 12'hB00, 32'h104);
        rd("minstret_resume", 12'hB02, 32'h22);
        rd("mcycleh_held", 12'hB80, 32'h1);

        // Reset overrides a trap and a counter write in the same cycle
        rst = 1'b1; ent_trap = 1'b1; trap_pc = 32'h3000;
        wr(2'b01, 12'hB00, 32'h55);
        rst = 1'b0; ent_trap = 1'b0;
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h1800);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
